// File: rtl/serial_addsub_unit.sv
// Bit-serial W-bit add/subtract responder: accepts {a, b, sel} on a ready/valid request,
// computes LSB first one bit per clock, and holds {s, cout, ovf} until the result is consumed.
module serial_addsub_unit #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [0:W-1] a,
   input  logic [0:W-1] b,
   input  logic         sel,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [0:W-1] s,
   output logic         cout,
   output logic         ovf
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_n;
   logic [0:W-1]    a_q, b_q;
   logic            sel_q;
   logic            carry;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   idx;
   logic            last;
   logic            bit_a, bit_b, bit_s, carry_n;
   logic            accept;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == DONE);
   assign accept    = req_valid && req_ready;

   // Bit 0 is the MSB, so the LSB-first step count maps to a descending index.
   assign idx     = CW'(W - 1) - cnt;
   assign last    = (cnt == CW'(W - 1));
   assign bit_a   = a_q[idx];
   assign bit_b   = b_q[idx] ^ sel_q;
   assign bit_s   = bit_a ^ bit_b ^ carry;
   assign carry_n = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = RUN;
         RUN:     if (last) state_n = DONE;
         DONE:    if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= 1'b0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q   <= a;
                  b_q   <= b;
                  sel_q <= sel;
                  // Initial carry of 1 supplies the +1 of a + ~b + 1.
                  carry <= sel;
                  cnt   <= '0;
               end
            end
            RUN: begin
               s[idx] <= bit_s;
               carry  <= carry_n;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  cout <= carry_n;
                  ovf  <= carry ^ carry_n;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Randomized and directed self-checking bench for serial_addsub_unit (W=4) against an
// integer-arithmetic reference model.
module tb_serial_addsub_unit;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [0:W-1] a, b;
   logic         sel;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [0:W-1] s;
   logic         cout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;

   serial_addsub_unit #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .a(a), .b(b), .sel(sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .s(s), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {cout, ovf, s[3:0]} from plain unsigned/signed arithmetic.
   function automatic logic [5:0] model(input int x, input int y, input bit sub);
      int u, sx, sy, r;
      logic c, o;
      u  = sub ? (x - y) : (x + y);
      c  = sub ? (x >= y) : (u > 15);
      sx = (x > 7) ? x - 16 : x;
      sy = (y > 7) ? y - 16 : y;
      r  = sub ? (sx - sy) : (sx + sy);
      o  = (r > 7) || (r < -8);
      return {c, o, 4'(u & 15)};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input int x, input int y, input bit sub, input int hold,
                        input bit scramble);
      logic [5:0] e;
      e = model(x, y, sub);
      chk("req_ready_idle", req_ready, 1);
      a = 4'(x); b = 4'(y); sel = sub; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("req_ready_run", req_ready, 0);
      for (int k = 1; k <= W; k++) begin
         if (scramble) begin
            a = 4'($urandom); b = 4'($urandom); sel = 1'($urandom);
            req_valid = 1'($urandom); rsp_ready = 1'($urandom);
         end
         step();
         req_valid = 1'b0; rsp_ready = 1'b0;
         if (k < W) chk("rsp_valid_early", rsp_valid, 0);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("s", s, e[3:0]);
      chk("cout", cout, e[5]);
      chk("ovf", ovf, e[4]);
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'($urandom);
         a = 4'($urandom); b = 4'($urandom); sel = 1'($urandom);
         step();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_result", {cout, ovf, s}, e);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("consume_rsp_valid", rsp_valid, 0);
      chk("consume_req_ready", req_ready, 1);
      chk("held_result", {cout, ovf, s}, e);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      a = '0; b = '0; sel = 1'b0;
      #12;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_result", {cout, ovf, s}, 0);
      rst = 1'b0;
      step();

      do_op(1, 1, 0, 0, 0);
      do_op(1, 1, 1, 0, 0);
      do_op(15, 15, 0, 0, 0);
      do_op(7, 1, 0, 0, 0);
      do_op(1, 4, 1, 0, 0);
      do_op(4, 4, 1, 0, 0);
      do_op(8, 1, 1, 10, 0);
      do_op(7, 9, 1, 0, 1);

      // Abort mid-run with a nonzero prior result and nonzero partial sum.
      a = 4'd7; b = 4'd1; sel = 1'b0; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("abort_req_ready", req_ready, 1);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_result", {cout, ovf, s}, 0);
      #2;
      rst = 1'b0;
      step();

      for (int n = 0; n < 40; n++)
         do_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
               1'($urandom), int'($urandom_range(3, 0)), 1'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
